spi_bank_sched: RTL and testbench
=================================

SPI_BANK_SCHED -- requirements
Module: spi_bank_sched

Interface
REQ-001 SHALL have parameter BUF_SIZE, default 6: words per bank per direction.
REQ-002 SHALL have parameter CNT_W, default 3: counter width, at least ceil(log2(BUF_SIZE+1)).
REQ-003 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port signal_cycle  in  1  NITTA computation-cycle boundary pulse.
REQ-006 SHALL have port signal_wr  in  1  NITTA write strobe into the NITTA-owned tx bank.
REQ-007 SHALL have port cs  in  1  SPI chip select, active-low, already synchronised to clk.
REQ-008 SHALL have port spi_ready  in  1  SPI driver word-complete pulse.
REQ-009 SHALL have port bank_nitta  out  1  bank pair owned by NITTA; the SPI side owns the other bank.
REQ-010 SHALL have port buf_clr  out  2  one-cycle pointer-reset pulse, one bit per bank.
REQ-011 SHALL have port nitta_wr_cnt  out  CNT_W  words NITTA wrote since the last swap.
REQ-012 SHALL have port spi_word_cnt  out  CNT_W  SPI words completed in the current transaction.
REQ-013 SHALL have port flag_start  out  1  one-cycle pulse at transaction start.
REQ-014 SHALL have port flag_stop  out  1  one-cycle pulse at transaction end.
REQ-015 SHALL have port swap_cnt  out  8  number of completed swaps.
REQ-016 SHALL have port err_ovf  out  1  sticky flag: a buffer overflowed.
REQ-017 SHALL have port err_late  out  1  sticky flag: a swap deadline was missed.

Function
REQ-018 SHALL register cs into cs_d; fall = cs_d & !cs, rise = !cs_d & cs.
REQ-019 SHALL pulse flag_start in the cycle after a fall and flag_stop in the cycle after a rise, each exactly one cycle.
REQ-020 SHALL implement the FSM states IDLE, XFER, WAIT_CYC, WAIT_XFER and SWAP.
REQ-021 IDLE SHALL go: fall -> XFER; signal_cycle -> WAIT_XFER; both in the same cycle -> WAIT_XFER.
REQ-022 XFER SHALL go: rise & signal_cycle in the same cycle -> SWAP; rise alone -> WAIT_CYC; signal_cycle alone -> WAIT_XFER.
REQ-023 WAIT_CYC SHALL go -> SWAP on signal_cycle; a fall here SHALL set err_late, and the FSM SHALL stay in WAIT_CYC while SPI reuses the stale bank.
REQ-024 WAIT_XFER SHALL go -> SWAP on rise; a further signal_cycle here SHALL set err_late and the FSM SHALL stay.
REQ-025 SWAP SHALL last one cycle.
REQ-026 During SWAP, bank_nitta SHALL toggle, effective from the next cycle.
REQ-027 During SWAP, buf_clr SHALL pulse on both bits.
REQ-028 During SWAP, nitta_wr_cnt SHALL be cleared and swap_cnt SHALL increment, wrapping 255 -> 0.
REQ-029 From SWAP, next state SHALL be XFER if cs is low, else IDLE.
REQ-030 A fall during SWAP SHALL be deferred: it SHALL still produce flag_start, and spi_word_cnt SHALL count against the new bank.
REQ-031 nitta_wr_cnt SHALL increment on signal_wr, saturating at BUF_SIZE.
REQ-032 signal_wr while nitta_wr_cnt == BUF_SIZE SHALL set err_ovf.
REQ-033 signal_wr in the SWAP cycle SHALL count as 1 toward the new bank.
REQ-034 spi_word_cnt SHALL clear on fall and increment on spi_ready while cs is low, saturating at BUF_SIZE.
REQ-035 spi_ready while spi_word_cnt == BUF_SIZE SHALL set err_ovf.
REQ-036 spi_ready while cs is high SHALL be ignored.
REQ-037 err_ovf and err_late SHALL clear only on reset.
REQ-038 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-039 On rst low, all state SHALL clear immediately: state=IDLE, cs_d=1, bank_nitta=0, buf_clr=0, all counters=0, flags=0, errors=0.
REQ-040 Reset asserted mid-transaction SHALL abort it without a flag_stop.
REQ-041 After rst is released with cs already low, the first edge SHALL be detected only after cs goes high and then low again.

Verification
REQ-042 Nominal: 3 signal_wr, then cs low, 3 spi_ready, cs high, then signal_cycle -> flag_start 1 cycle, flag_stop 1 cycle, SWAP, bank_nitta 0->1, buf_clr=2'b11 once, swap_cnt=1, nitta_wr_cnt=0.
REQ-043 Cycle first: signal_cycle in IDLE, then a full cs low/high frame -> swap on the cycle after the rise, bank_nitta=1, err_late=0.
REQ-044 Simultaneous: cs rise and signal_cycle in the same cycle while in XFER -> SWAP the next cycle, swap_cnt=1.
REQ-045 Overflow: 7 signal_wr with BUF_SIZE=6 -> nitta_wr_cnt stays 6, err_ovf=1, and err_ovf stays 1 after a later swap.
REQ-046 Late: two signal_cycle pulses while cs stays low -> err_late=1, exactly one swap after the rise, swap_cnt=1.
REQ-047 Async reset mid-XFER with 2 spi_ready counted -> all outputs 0 immediately without waiting for clk, no flag_stop; 256 completed swaps -> swap_cnt wraps to 0.

Source files
------------

// File: rtl/spi_bank_sched_if.sv
// Handshake bundle between the NITTA/SPI glue and the bank scheduler.
// The scheduler attaches through the slave modport; the environment uses master.
interface spi_bank_sched_if #(
    parameter int CNT_W = 3
);
    logic             signal_cycle;
    logic             signal_wr;
    logic             cs;
    logic             spi_ready;
    logic             bank_nitta;
    logic [1:0]       buf_clr;
    logic [CNT_W-1:0] nitta_wr_cnt;
    logic [CNT_W-1:0] spi_word_cnt;
    logic             flag_start;
    logic             flag_stop;
    logic [7:0]       swap_cnt;
    logic             err_ovf;
    logic             err_late;

    modport master (
        output signal_cycle, signal_wr, cs, spi_ready,
        input  bank_nitta, buf_clr, nitta_wr_cnt, spi_word_cnt,
               flag_start, flag_stop, swap_cnt, err_ovf, err_late
    );

    modport slave (
        input  signal_cycle, signal_wr, cs, spi_ready,
        output bank_nitta, buf_clr, nitta_wr_cnt, spi_word_cnt,
               flag_start, flag_stop, swap_cnt, err_ovf, err_late
    );
endinterface

// File: rtl/spi_bank_sched.sv
// Ping-pong bank scheduler: NITTA owns one bank pair and SPI the other.
// Banks swap once both a computation cycle and an SPI frame have completed.
module spi_bank_sched #(
    parameter int BUF_SIZE = 6,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    spi_bank_sched_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        XFER      = 3'd1,
        WAIT_CYC  = 3'd2,
        WAIT_XFER = 3'd3,
        SWAP      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_SIZE);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

    state_t           state_r;
    state_t           state_next_s;
    logic             cs_d_r;
    logic             armed_r;
    logic             fall_s;
    logic             rise_s;
    logic             late_set_s;
    logic             wr_ovf_s;
    logic             spi_ovf_s;
    logic             bank_nitta_r;
    logic [1:0]       buf_clr_r;
    logic [CNT_W-1:0] nitta_wr_cnt_r;
    logic [CNT_W-1:0] spi_word_cnt_r;
    logic             flag_start_r;
    logic             flag_stop_r;
    logic [7:0]       swap_cnt_r;
    logic             err_ovf_r;
    logic             err_late_r;

    // Edges only count once cs has been seen high after reset, so a frame
    // already in flight at reset release is ignored until it ends.
    assign fall_s    = armed_r & cs_d_r & ~bus.cs;
    assign rise_s    = armed_r & ~cs_d_r & bus.cs;
    assign wr_ovf_s  = bus.signal_wr & (state_r != SWAP) & (nitta_wr_cnt_r == FULL_CNT);
    assign spi_ovf_s = bus.spi_ready & ~bus.cs & ~fall_s & (spi_word_cnt_r == FULL_CNT);

    // Delayed chip select and edge-arming register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_d_r  <= 1'b1;
            armed_r <= 1'b0;
        end else begin
            cs_d_r  <= bus.cs;
            armed_r <= armed_r | bus.cs;
        end
    end

    // Next-state decode and deadline-miss detection.
    always_comb begin
        state_next_s = state_r;
        late_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.signal_cycle) begin
                    state_next_s = WAIT_XFER;
                end else if (fall_s) begin
                    state_next_s = XFER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            XFER: begin
                if (rise_s && bus.signal_cycle) begin
                    state_next_s = SWAP;
                end else if (rise_s) begin
                    state_next_s = WAIT_CYC;
                end else if (bus.signal_cycle) begin
                    state_next_s = WAIT_XFER;
                end else begin
                    state_next_s = XFER;
                end
            end
            WAIT_CYC: begin
                if (bus.signal_cycle) begin
                    state_next_s = SWAP;
                end else if (fall_s) begin
                    late_set_s   = 1'b1;
                    state_next_s = WAIT_CYC;
                end else begin
                    state_next_s = WAIT_CYC;
                end
            end
            WAIT_XFER: begin
                late_set_s = bus.signal_cycle;
                if (rise_s) begin
                    state_next_s = SWAP;
                end else begin
                    state_next_s = WAIT_XFER;
                end
            end
            SWAP: begin
                if (!bus.cs) begin
                    state_next_s = XFER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // One-cycle transaction flags and the pointer-reset pulse, which is
    // high exactly while the FSM sits in SWAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_start_r <= 1'b0;
            flag_stop_r  <= 1'b0;
            buf_clr_r    <= 2'b00;
        end else begin
            flag_start_r <= fall_s;
            flag_stop_r  <= rise_s;
            buf_clr_r    <= (state_next_s == SWAP) ? 2'b11 : 2'b00;
        end
    end

    // Bank ownership and swap counter advance at the end of SWAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_nitta_r <= 1'b0;
            swap_cnt_r   <= 8'd0;
        end else if (state_r == SWAP) begin
            bank_nitta_r <= ~bank_nitta_r;
            swap_cnt_r   <= swap_cnt_r + 8'd1;
        end else begin
            bank_nitta_r <= bank_nitta_r;
            swap_cnt_r   <= swap_cnt_r;
        end
    end

    // NITTA write counter; a write in SWAP lands in the freshly owned bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nitta_wr_cnt_r <= ZERO_CNT;
        end else if (state_r == SWAP) begin
            nitta_wr_cnt_r <= bus.signal_wr ? ONE_CNT : ZERO_CNT;
        end else if (bus.signal_wr && (nitta_wr_cnt_r != FULL_CNT)) begin
            nitta_wr_cnt_r <= nitta_wr_cnt_r + ONE_CNT;
        end else begin
            nitta_wr_cnt_r <= nitta_wr_cnt_r;
        end
    end

    // SPI word counter for the current frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spi_word_cnt_r <= ZERO_CNT;
        end else if (fall_s) begin
            spi_word_cnt_r <= ZERO_CNT;
        end else if (bus.spi_ready && !bus.cs && (spi_word_cnt_r != FULL_CNT)) begin
            spi_word_cnt_r <= spi_word_cnt_r + ONE_CNT;
        end else begin
            spi_word_cnt_r <= spi_word_cnt_r;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ovf_r  <= 1'b0;
            err_late_r <= 1'b0;
        end else begin
            err_ovf_r  <= err_ovf_r | wr_ovf_s | spi_ovf_s;
            err_late_r <= err_late_r | late_set_s;
        end
    end

    assign bus.bank_nitta   = bank_nitta_r;
    assign bus.buf_clr      = buf_clr_r;
    assign bus.nitta_wr_cnt = nitta_wr_cnt_r;
    assign bus.spi_word_cnt = spi_word_cnt_r;
    assign bus.flag_start   = flag_start_r;
    assign bus.flag_stop    = flag_stop_r;
    assign bus.swap_cnt     = swap_cnt_r;
    assign bus.err_ovf      = err_ovf_r;
    assign bus.err_late     = err_late_r;

endmodule

// File: tb/tb_spi_bank_sched.sv
// Directed bench for spi_bank_sched with hand-computed expectations.
module tb_spi_bank_sched;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    spi_bank_sched_if #(.CNT_W(3)) bus ();

    spi_bank_sched #(.BUF_SIZE(6), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".bank"},  32'(bus.bank_nitta),   32'd0);
        check_val({tag, ".clr"},   32'(bus.buf_clr),      32'd0);
        check_val({tag, ".wr"},    32'(bus.nitta_wr_cnt), 32'd0);
        check_val({tag, ".words"}, 32'(bus.spi_word_cnt), 32'd0);
        check_val({tag, ".start"}, 32'(bus.flag_start),   32'd0);
        check_val({tag, ".stop"},  32'(bus.flag_stop),    32'd0);
        check_val({tag, ".swaps"}, 32'(bus.swap_cnt),     32'd0);
        check_val({tag, ".ovf"},   32'(bus.err_ovf),      32'd0);
        check_val({tag, ".late"},  32'(bus.err_late),     32'd0);
    endtask

    task automatic do_reset();
        bus.signal_cycle = 1'b0;
        bus.signal_wr    = 1'b0;
        bus.spi_ready    = 1'b0;
        bus.cs           = 1'b1;
        rst              = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Cycle-first frame from IDLE: cycle pulse, cs low, cs high, SWAP.
    task automatic swap_frame();
        bus.signal_cycle = 1'b1;
        step();
        bus.signal_cycle = 1'b0;
        bus.cs = 1'b0;
        step();
        bus.cs = 1'b1;
        step();
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst              = 1'b0;
        bus.cs           = 1'b1;
        bus.signal_cycle = 1'b0;
        bus.signal_wr    = 1'b0;
        bus.spi_ready    = 1'b0;
        #12;
        check_all_zero("reset");

        // Nominal frame
        do_reset();
        check_all_zero("post_reset");
        bus.signal_wr = 1'b1;
        repeat (3) step();
        bus.signal_wr = 1'b0;
        check_val("nom.wr_cnt", 32'(bus.nitta_wr_cnt), 32'd3);
        bus.cs = 1'b0;
        step();
        check_val("nom.start", 32'(bus.flag_start), 32'd1);
        bus.spi_ready = 1'b1;
        step();
        check_val("nom.start_once", 32'(bus.flag_start), 32'd0);
        repeat (2) step();
        bus.spi_ready = 1'b0;
        check_val("nom.words", 32'(bus.spi_word_cnt), 32'd3);
        bus.cs = 1'b1;
        step();
        check_val("nom.stop", 32'(bus.flag_stop), 32'd1);
        step();
        check_val("nom.stop_once", 32'(bus.flag_stop), 32'd0);
        check_val("nom.no_early_swap", 32'(bus.buf_clr), 32'd0);
        bus.signal_cycle = 1'b1;
        step();
        bus.signal_cycle = 1'b0;
        check_val("nom.clr", 32'(bus.buf_clr), 32'd3);
        check_val("nom.bank_old", 32'(bus.bank_nitta), 32'd0);
        step();
        check_val("nom.clr_once", 32'(bus.buf_clr), 32'd0);
        check_val("nom.bank_new", 32'(bus.bank_nitta), 32'd1);
        check_val("nom.swaps", 32'(bus.swap_cnt), 32'd1);
        check_val("nom.wr_clr", 32'(bus.nitta_wr_cnt), 32'd0);
        check_val("nom.late", 32'(bus.err_late), 32'd0);

        // Cycle arrives before the frame
        do_reset();
        bus.signal_cycle = 1'b1;
        step();
        bus.signal_cycle = 1'b0;
        bus.cs = 1'b0;
        step();
        check_val("cyc.start", 32'(bus.flag_start), 32'd1);
        bus.cs = 1'b1;
        step();
        check_val("cyc.clr", 32'(bus.buf_clr), 32'd3);
        step();
        check_val("cyc.bank", 32'(bus.bank_nitta), 32'd1);
        check_val("cyc.late", 32'(bus.err_late), 32'd0);

        // Rise and cycle together in XFER
        do_reset();
        bus.cs = 1'b0;
        step();
        step();
        bus.cs = 1'b1;
        bus.signal_cycle = 1'b1;
        step();
        bus.signal_cycle = 1'b0;
        check_val("sim.clr", 32'(bus.buf_clr), 32'd3);
        check_val("sim.stop", 32'(bus.flag_stop), 32'd1);
        step();
        check_val("sim.swaps", 32'(bus.swap_cnt), 32'd1);
        check_val("sim.bank", 32'(bus.bank_nitta), 32'd1);

        // NITTA overflow, sticky across a swap, write during SWAP counts once
        do_reset();
        bus.signal_wr = 1'b1;
        repeat (7) step();
        bus.signal_wr = 1'b0;
        check_val("ovf.wr_sat", 32'(bus.nitta_wr_cnt), 32'd6);
        check_val("ovf.flag", 32'(bus.err_ovf), 32'd1);
        bus.signal_cycle = 1'b1;
        step();
        bus.signal_cycle = 1'b0;
        bus.cs = 1'b0;
        step();
        bus.cs = 1'b1;
        step();
        check_val("ovf.clr", 32'(bus.buf_clr), 32'd3);
        bus.signal_wr = 1'b1;
        step();
        bus.signal_wr = 1'b0;
        check_val("ovf.swap_wr", 32'(bus.nitta_wr_cnt), 32'd1);
        check_val("ovf.swaps", 32'(bus.swap_cnt), 32'd1);
        check_val("ovf.sticky", 32'(bus.err_ovf), 32'd1);

        // SPI side: ready ignored with cs high, saturation and overflow
        do_reset();
        bus.spi_ready = 1'b1;
        repeat (2) step();
        bus.spi_ready = 1'b0;
        check_val("spi.ignore", 32'(bus.spi_word_cnt), 32'd0);
        bus.cs = 1'b0;
        step();
        bus.spi_ready = 1'b1;
        repeat (6) step();
        check_val("spi.full", 32'(bus.spi_word_cnt), 32'd6);
        check_val("spi.no_ovf_yet", 32'(bus.err_ovf), 32'd0);
        step();
        bus.spi_ready = 1'b0;
        check_val("spi.sat", 32'(bus.spi_word_cnt), 32'd6);
        check_val("spi.ovf", 32'(bus.err_ovf), 32'd1);

        // Two cycle pulses during one long frame
        do_reset();
        bus.cs = 1'b0;
        step();
        bus.signal_cycle = 1'b1;
        step();
        bus.signal_cycle = 1'b0;
        step();
        check_val("late.none_yet", 32'(bus.err_late), 32'd0);
        bus.signal_cycle = 1'b1;
        step();
        bus.signal_cycle = 1'b0;
        check_val("late.flag", 32'(bus.err_late), 32'd1);
        check_val("late.no_swap", 32'(bus.swap_cnt), 32'd0);
        bus.cs = 1'b1;
        step();
        check_val("late.clr", 32'(bus.buf_clr), 32'd3);
        repeat (3) step();
        check_val("late.one_swap", 32'(bus.swap_cnt), 32'd1);
        check_val("late.sticky", 32'(bus.err_late), 32'd1);

        // Async reset mid-frame, then release while cs is low
        do_reset();
        bus.cs = 1'b0;
        step();
        bus.spi_ready = 1'b1;
        repeat (2) step();
        bus.spi_ready = 1'b0;
        check_val("arst.words", 32'(bus.spi_word_cnt), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("arst");
        step();
        rst = 1'b1;
        step();
        check_val("arst.no_start0", 32'(bus.flag_start), 32'd0);
        step();
        check_val("arst.no_start1", 32'(bus.flag_start), 32'd0);
        bus.cs = 1'b1;
        step();
        check_val("arst.no_stop", 32'(bus.flag_stop), 32'd0);
        step();
        bus.cs = 1'b0;
        step();
        check_val("arst.rearmed", 32'(bus.flag_start), 32'd1);

        // Swap counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) begin
            swap_frame();
        end
        check_val("wrap.255", 32'(bus.swap_cnt), 32'd255);
        check_val("wrap.bank_odd", 32'(bus.bank_nitta), 32'd1);
        swap_frame();
        check_val("wrap.0", 32'(bus.swap_cnt), 32'd0);
        check_val("wrap.bank_even", 32'(bus.bank_nitta), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
